// File: rtl/sensor_mon_pkg.sv
// rtl/sensor_mon_pkg.sv - shared state type, defaults and error rule for the sensor monitor
//
// Purpose : types and constants imported by sample_timer and sensor_monitor_ctrl.
// Contents: mon_state_t FSM encoding, default SAMPLE_PERIOD / CONFIRM_CNT,
//           eval_err() combining the four raw sensor lines into one error flag.
// Ports   : none (package).

package sensor_mon_pkg;

  localparam int SAMPLE_PERIOD_DEF = 8;
  localparam int CONFIRM_CNT_DEF   = 3;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MONITOR = 3'd1,
    CONFIRM = 3'd2,
    ALARM   = 3'd3,
    CLEAR   = 3'd4
  } mon_state_t;

  // Line 0 is a hard fault on its own; line 1 only counts when backed by 2 or 3.
  function automatic logic eval_err(input logic [3:0] s);
    return s[0] | (s[1] & (s[2] | s[3]));
  endfunction

endpackage

// File: rtl/sensor_monitor_ctrl_sample_timer.sv
// rtl/sensor_monitor_ctrl_sample_timer.sv - free-running sample period timer
//
// Purpose : counts 0..PERIOD-1 while enabled and flags the last count as a tick.
// Ports   : clk    - clock, rising edge
//           rst    - synchronous active-high reset
//           clear  - synchronous counter clear (monitoring disabled)
//           enable - count enable
//           tick   - high during the cycle the counter sits at PERIOD-1

module sample_timer
  import sensor_mon_pkg::*;
#(
  parameter int PERIOD = SAMPLE_PERIOD_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int            CW   = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  logic [CW-1:0] r_count;
  logic          w_last;

  assign w_last = (r_count == LAST);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= w_last ? '0 : r_count + CW'(1);
    end
  end

  assign tick = enable && w_last;

endmodule

// File: rtl/sensor_monitor_ctrl.sv
// rtl/sensor_monitor_ctrl.sv - debounced sensor error monitor with alarm/ack handshake
//
// Purpose : samples the sensor lines every SAMPLE_PERIOD cycles, confirms an error
//           over CONFIRM_CNT consecutive samples, raises alarm until the host acks,
//           then waits for one clean sample before monitoring again.
// Ports   : clk           - clock, rising edge
//           rst           - synchronous active-high reset
//           enable        - monitoring enable; low forces IDLE
//           sensors[3:0]  - raw sensor lines
//           ack           - alarm acknowledge (only honoured in ALARM)
//           alarm         - confirmed error, held until acknowledged
//           pending       - high while confirming an error
//           sample_strobe - one-cycle pulse when err_sample updates
//           err_sample    - registered error flag of the latest sample
//           alarm_count   - [SENSOR_MON_LOG_EN] saturating count of ALARM entries
//           alarm_snapshot- [SENSOR_MON_LOG_EN] sensors captured for the alarming sample
// Build   : define SENSOR_MON_LOG_EN to add the alarm log outputs.

module sensor_monitor_ctrl
  import sensor_mon_pkg::*;
#(
  parameter int SAMPLE_PERIOD = SAMPLE_PERIOD_DEF,
  parameter int CONFIRM_CNT   = CONFIRM_CNT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [3:0] sensors,
  input  logic       ack,
  output logic       alarm,
  output logic       pending,
  output logic       sample_strobe,
  output logic       err_sample
`ifdef SENSOR_MON_LOG_EN
  ,
  output logic [7:0] alarm_count,
  output logic [3:0] alarm_snapshot
`endif
);

  localparam logic [3:0] LP_CONFIRM = 4'(CONFIRM_CNT);

  mon_state_t r_state;
  mon_state_t w_next_state;
  logic [3:0] r_hit_cnt;
  logic [3:0] w_next_hit;
  logic [3:0] w_hit_inc;
  logic       r_alarm;
  logic       r_pending;
  logic       r_strobe;
  logic       r_err;
  logic       w_tick;
  logic       w_timer_clear;

  // Disabling monitoring restarts the sample window from zero.
  assign w_timer_clear = ~enable;

  sample_timer #(
    .PERIOD (SAMPLE_PERIOD)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (w_timer_clear),
    .enable (enable),
    .tick   (w_tick)
  );

  // Sample path: capture on tick, strobe the cycle after so the FSM sees the new flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err    <= 1'b0;
      r_strobe <= 1'b0;
    end else begin
      r_strobe <= w_tick;
      if (w_tick) begin
        r_err <= eval_err(sensors);
      end
    end
  end

  assign w_hit_inc = r_hit_cnt + 4'd1;

  always_comb begin
    w_next_state = r_state;
    w_next_hit   = r_hit_cnt;
    if (!enable) begin
      w_next_state = IDLE;
      w_next_hit   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          w_next_state = MONITOR;
          w_next_hit   = '0;
        end
        MONITOR: begin
          if (r_strobe && r_err) begin
            w_next_hit   = 4'd1;
            w_next_state = (LP_CONFIRM == 4'd1) ? ALARM : CONFIRM;
          end
        end
        CONFIRM: begin
          if (r_strobe) begin
            if (r_err) begin
              w_next_hit = w_hit_inc;
              if (w_hit_inc >= LP_CONFIRM) begin
                w_next_state = ALARM;
              end
            end else begin
              w_next_hit   = '0;
              w_next_state = MONITOR;
            end
          end
        end
        ALARM: begin
          // Strobes are ignored here; only ack moves on.
          if (ack) begin
            w_next_state = CLEAR;
            w_next_hit   = '0;
          end
        end
        CLEAR: begin
          // A persistent fault keeps us here; one clean sample re-arms.
          if (r_strobe && !r_err) begin
            w_next_state = MONITOR;
          end
        end
        default: begin
          w_next_state = IDLE;
          w_next_hit   = '0;
        end
      endcase
    end
  end

  // State plus outputs decoded from the next state, so alarm/pending are registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_hit_cnt <= '0;
      r_alarm   <= 1'b0;
      r_pending <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_hit_cnt <= w_next_hit;
      r_alarm   <= (w_next_state == ALARM);
      r_pending <= (w_next_state == CONFIRM);
    end
  end

  assign alarm         = r_alarm;
  assign pending       = r_pending;
  assign sample_strobe = r_strobe;
  assign err_sample    = r_err;

`ifdef SENSOR_MON_LOG_EN
  logic [7:0] r_alarm_count;
  logic [3:0] r_alarm_snapshot;
  logic [3:0] r_tick_sensors;
  logic       w_alarm_entry;

  assign w_alarm_entry = (w_next_state == ALARM) && (r_state != ALARM);

  // r_tick_sensors holds the raw lines behind the current err_sample, so on
  // entry (a strobe cycle) it is exactly the sample that caused the alarm.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_alarm_count    <= '0;
      r_alarm_snapshot <= '0;
      r_tick_sensors   <= '0;
    end else begin
      if (w_tick) begin
        r_tick_sensors <= sensors;
      end
      if (w_alarm_entry) begin
        if (r_alarm_count != 8'hFF) begin
          r_alarm_count <= r_alarm_count + 8'd1;
        end
        r_alarm_snapshot <= r_tick_sensors;
      end
    end
  end

  assign alarm_count    = r_alarm_count;
  assign alarm_snapshot = r_alarm_snapshot;
`endif

endmodule

// File: doc/sensor_monitor_ctrl.md
SENSOR_MONITOR_CTRL -- requirements
Module: sensor_monitor_ctrl

Interface
REQ-001 The block SHALL have parameter SAMPLE_PERIOD, default 8: cycles between sensor samples (range 2..256).
REQ-002 The block SHALL have parameter CONFIRM_CNT, default 3: consecutive erroring samples needed to raise an alarm (range 1..15).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port enable, input, 1 bit: monitoring enable.
REQ-006 The block SHALL have port sensors, input, 4 bits: raw sensor lines.
REQ-007 The block SHALL have port ack, input, 1 bit: alarm acknowledge from the host.
REQ-008 The block SHALL have port alarm, output, 1 bit: confirmed error, held until acknowledged.
REQ-009 The block SHALL have port pending, output, 1 bit: high while the FSM is in CONFIRM.
REQ-010 The block SHALL have port sample_strobe, output, 1 bit: one-cycle pulse when err_sample updates.
REQ-011 The block SHALL have port err_sample, output, 1 bit: registered error flag of the latest sample.

Function
REQ-012 The sample timer SHALL count 0..SAMPLE_PERIOD-1 while enable=1, wrap to 0, and assert tick when count==SAMPLE_PERIOD-1.
REQ-013 On tick, the block SHALL set err_sample <= sensors[0] | (sensors[1] & (sensors[2] | sensors[3])), and sample_strobe SHALL be 1 in the following cycle only.
REQ-014 The FSM SHALL have states IDLE, MONITOR, CONFIRM, ALARM and CLEAR, and SHALL evaluate err_sample only in cycles where sample_strobe=1.
REQ-015 In IDLE, enable=1 SHALL move to MONITOR; in every state, enable=0 SHALL force IDLE, clear the timer, clear hit_cnt and drop alarm on the next edge.
REQ-016 In MONITOR, strobe with err=1 SHALL set hit_cnt=1 and go to CONFIRM, or go directly to ALARM when CONFIRM_CNT==1.
REQ-017 In CONFIRM, strobe with err=1 SHALL increment hit_cnt and go to ALARM when hit_cnt reaches CONFIRM_CNT; strobe with err=0 SHALL clear hit_cnt and return to MONITOR.
REQ-018 In ALARM, alarm SHALL be 1; ack=1 SHALL move to CLEAR; strobes SHALL be ignored.
REQ-019 In CLEAR, alarm SHALL be 0; the FSM SHALL return to MONITOR only on a strobe with err=0, and a strobe with err=1 SHALL keep it in CLEAR, so a persistent fault never re-alarms until cleared.
REQ-020 alarm SHALL assert in the cycle after the CONFIRM_CNT-th consecutive erroring strobe; pending SHALL equal (state==CONFIRM).
REQ-021 hit_cnt SHALL be 4 bits wide and SHALL never exceed CONFIRM_CNT.
REQ-022 If ack and a strobe coincide in ALARM, ack SHALL take precedence.
REQ-023 ack SHALL be ignored outside ALARM.

Reset
REQ-024 While rst=1 at a rising edge, the block SHALL set the FSM to IDLE and timer, hit_cnt, err_sample, sample_strobe, alarm and pending to 0, regardless of enable.
REQ-025 rst SHALL override all other inputs, including mid-CONFIRM and mid-ALARM.

Configuration
REQ-026 With SENSOR_MON_LOG_EN defined, the block SHALL add output alarm_count (8 bits, incremented on each entry to ALARM, saturating at 255, cleared only by rst) and output alarm_snapshot (4 bits, the sensors value captured at the tick whose sample caused entry to ALARM).
REQ-027 Without SENSOR_MON_LOG_EN, those ports and their registers SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-028 Package sensor_mon_pkg SHALL hold the state enum typedef (IDLE, MONITOR, CONFIRM, ALARM, CLEAR) and the default constants for SAMPLE_PERIOD and CONFIRM_CNT.
REQ-029 The sample timer SHALL be a separate sub-module, sample_timer (parameter PERIOD; ports clk, rst, clear, enable, tick); the FSM, error evaluation and log SHALL reside in the top module.

Verification (SAMPLE_PERIOD=4, CONFIRM_CNT=3; enable rises at cycle 0)
REQ-030 The bench SHALL check: rst=1 for 2 cycles with sensors=4'hF -> alarm, pending, sample_strobe and err_sample all 0.
REQ-031 The bench SHALL check: sensors=4'b0001 held -> strobes at cycles 4, 8 and 12; pending=1 from cycle 5; alarm=1 from cycle 13.
REQ-032 The bench SHALL check: sensors=4'b1010 for 2 samples then 4'b1000 -> pending drops after the third strobe; alarm stays 0.
REQ-033 The bench SHALL check: in ALARM, ack pulse with sensors still 4'b0110 -> alarm drops next cycle; no re-alarm until one sample with sensors=0, then 3 erroring samples -> alarm.
REQ-034 The bench SHALL check: rst asserted while pending=1 -> IDLE next edge; with enable held, re-arm requires 3 fresh erroring samples.
REQ-035 The bench SHALL check, with SENSOR_MON_LOG_EN: two alarm/ack cycles with the last cause 4'b1010 -> alarm_count=2, alarm_snapshot=4'b1010; 300 alarms -> alarm_count=255.
